// File: rtl/proc_trace_monitor.sv
// Trace monitor for the MIPS core: logs register-tap changes into a FIFO,
// counts cycles/instructions and detects a stuck PC (halt).
module proc_trace_monitor #(
    parameter int NUM_WATCH   = 4,
    parameter int DEPTH       = 16,
    parameter int HALT_CYCLES = 8,
    parameter int CNT_W       = 32,
    localparam int IDW        = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic                    in_valid,
    input  logic [31:0]             in_pc,
    input  logic [32*NUM_WATCH-1:0] in_regs,
    input  logic                    rd_ready,
    output logic                    rd_valid,
    output logic [32+IDW-1:0]       rd_data,
    output logic                    overflow,
    output logic                    halted,
    output logic [CNT_W-1:0]        cycle_count,
    output logic [CNT_W-1:0]        instr_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = $clog2(HALT_CYCLES);
    localparam logic [RW-1:0] RUN_MAX = RW'(HALT_CYCLES - 1);

    typedef enum logic {ST_RUN, ST_HALTED} state_t;

    logic [31:0]      r_shadow [NUM_WATCH];
    logic [32+IDW-1:0] r_mem   [DEPTH];
    logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    state_t           r_state, w_state_nxt;
    logic [RW-1:0]    r_run, w_run_nxt;
    logic [31:0]      r_prev_pc;
    logic [CNT_W-1:0] r_cycles, r_instrs;

    logic             w_any;
    logic [IDW-1:0]   w_sel;
    logic [31:0]      w_val;
    logic             w_full, w_pop, w_push;

    // Scan from the top down so the lowest pending tap is the one left selected.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_val = '0;
        for (int unsigned i = NUM_WATCH; i > 0; i--) begin
            if (in_regs[32*(i-1) +: 32] != r_shadow[i-1]) begin
                w_any = 1'b1;
                w_sel = IDW'(i - 1);
                w_val = in_regs[32*(i-1) +: 32];
            end
        end
    end

    assign rd_valid = (r_count != '0);
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_pop    = rd_valid && rd_ready;
    assign w_push   = w_any && (!w_full || w_pop);

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= {w_sel, w_val};
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int unsigned i = 0; i < NUM_WATCH; i++) r_shadow[i] <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
            if (w_any && w_full && !w_pop) r_overflow <= 1'b1;
            for (int unsigned i = 0; i < NUM_WATCH; i++) begin
                if (w_push && w_sel == IDW'(i)) r_shadow[i] <= w_val;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        case (r_state)
            ST_RUN: begin
                if (in_valid) begin
                    if (in_pc == r_prev_pc) begin
                        if (r_run == RUN_MAX) w_state_nxt = ST_HALTED;
                        else                  w_run_nxt   = r_run + RW'(1);
                    end else begin
                        w_run_nxt = '0;
                    end
                end
            end
            ST_HALTED: w_state_nxt = ST_HALTED;
            default:   w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state   <= ST_RUN;
            r_run     <= '0;
            r_prev_pc <= '0;
            r_cycles  <= '0;
            r_instrs  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
            if (in_valid) r_prev_pc <= in_pc;
            // The cycle that enters HALTED still counts; state is still RUN here.
            if (r_state != ST_HALTED) begin
                r_cycles <= r_cycles + CNT_W'(1);
                if (in_valid) r_instrs <= r_instrs + CNT_W'(1);
            end
        end
    end

    assign rd_data     = rd_valid ? r_mem[r_rd_ptr] : '0;
    assign overflow    = r_overflow;
    assign halted      = (r_state == ST_HALTED);
    assign cycle_count = r_cycles;
    assign instr_count = r_instrs;
endmodule

// File: tb/tb_proc_trace_monitor.sv
// Bench for proc_trace_monitor: directed scenarios then random traffic,
// all compared against a queue-based reference model.
module tb_proc_trace_monitor;
    localparam int NW = 4;
    localparam int DP = 16;
    localparam int HC = 8;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic [31:0] pc  = '0;
    logic [31:0] regs [NW];
    logic        rdy = 1'b0;
    logic [32*NW-1:0] w_regs;
    logic        rd_valid, overflow, halted;
    logic [33:0] rd_data;
    logic [31:0] cycle_count, instr_count;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [33:0] mq [$];
    logic [31:0] msh [NW];
    bit          mov, mhalt;
    int unsigned mstreak;
    logic [31:0] mprev, mcyc, minstr;

    always #5 CLK = ~CLK;

    assign w_regs = {regs[3], regs[2], regs[1], regs[0]};

    proc_trace_monitor #(.NUM_WATCH(NW), .DEPTH(DP), .HALT_CYCLES(HC), .CNT_W(32)) dut (
        .CLK(CLK), .Reset(rst), .in_valid(vld), .in_pc(pc), .in_regs(w_regs),
        .rd_ready(rdy), .rd_valid(rd_valid), .rd_data(rd_data), .overflow(overflow),
        .halted(halted), .cycle_count(cycle_count), .instr_count(instr_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int sel;
        bit pop;
        if (rst) begin
            mq.delete();
            foreach (msh[i]) msh[i] = '0;
            mov = 0; mhalt = 0; mstreak = 0; mprev = '0; mcyc = '0; minstr = '0;
            return;
        end
        sel = -1;
        for (int i = NW - 1; i >= 0; i--) if (regs[i] != msh[i]) sel = i;
        pop = (mq.size() > 0) && rdy;
        if (pop) void'(mq.pop_front());
        if (sel >= 0) begin
            if (mq.size() < DP) begin
                mq.push_back({2'(sel), regs[sel]});
                msh[sel] = regs[sel];
            end else begin
                mov = 1;
            end
        end
        if (!mhalt) begin
            mcyc++;
            if (vld) begin
                minstr++;
                if (pc == mprev) mstreak++;
                else mstreak = 0;
                if (mstreak == HC) mhalt = 1;
            end
        end
        if (vld) mprev = pc;
    endtask

    task automatic check_all();
        chk("rd_valid", 64'(rd_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) chk("rd_data", 64'(rd_data), 64'(mq[0]));
        chk("overflow", 64'(overflow), 64'(mov));
        chk("halted", 64'(halted), 64'(mhalt));
        chk("cycle_count", 64'(cycle_count), 64'(mcyc));
        chk("instr_count", 64'(instr_count), 64'(minstr));
    endtask

    task automatic step();
        check_all();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    initial begin
        foreach (regs[i]) regs[i] = '0;
        // T1: reset then idle
        @(posedge CLK);
        model_edge();
        #1;
        chk("T1_rst_valid", 64'(rd_valid), 64'd0);
        chk("T1_rst_data", 64'(rd_data), 64'd0);
        chk("T1_rst_cycles", 64'(cycle_count), 64'd0);
        rst = 0;
        repeat (5) step();
        chk("T1_cycles", 64'(cycle_count), 64'd5);
        chk("T1_overflow", 64'(overflow), 64'd0);
        chk("T1_valid", 64'(rd_valid), 64'd0);

        // T2: single change, latency 1, then pop
        regs[2] = 32'h0000_00AA;
        step();
        chk("T2_valid", 64'(rd_valid), 64'd1);
        chk("T2_data", 64'(rd_data), {30'd0, 2'd2, 32'h0000_00AA});
        rdy = 1;
        step();
        chk("T2_empty", 64'(rd_valid), 64'd0);
        rdy = 0;

        // T3: three taps change together, logged lowest index first
        regs[0] = 32'h1; regs[1] = 32'h2; regs[3] = 32'h3;
        repeat (3) step();
        chk("T3_head", 64'(rd_data), {30'd0, 2'd0, 32'h1});
        rdy = 1;
        repeat (4) step();
        chk("T3_empty", 64'(rd_valid), 64'd0);
        rdy = 0;

        // T4: fill past capacity, then drain
        for (int k = 0; k < DP + 2; k++) begin
            regs[0] = 32'd100 + 32'(k);
            step();
        end
        chk("T4_overflow", 64'(overflow), 64'd1);
        chk("T4_head", 64'(rd_data), {30'd0, 2'd0, 32'd100});
        rdy = 1;
        repeat (DP + 3) step();
        chk("T4_drained", 64'(rd_valid), 64'd0);
        rdy = 0;

        // T5: stuck PC
        vld = 1; pc = 32'h40;
        repeat (8) step();
        chk("T5_not_yet", 64'(halted), 64'd0);
        step();
        chk("T5_halted", 64'(halted), 64'd1);
        repeat (3) step();
        chk("T5_frozen_cyc", 64'(cycle_count), 64'(mcyc));

        // T6: reset with entries queued and halted set
        regs[1] = 32'h5; regs[2] = 32'h6; regs[3] = 32'h7;
        repeat (3) step();
        chk("T6_queued", 64'(rd_valid), 64'd1);
        rst = 1;
        step();
        rst = 0; vld = 0;
        chk("T6_valid", 64'(rd_valid), 64'd0);
        chk("T6_data", 64'(rd_data), 64'd0);
        chk("T6_halted", 64'(halted), 64'd0);
        chk("T6_overflow", 64'(overflow), 64'd0);
        chk("T6_cycles", 64'(cycle_count), 64'd0);
        step();
        chk("T6_relog", 64'(rd_data), {30'd0, 2'd0, 32'd117});
        rdy = 1;
        repeat (6) step();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 149) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            vld = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) pc = 32'h40 + 32'($urandom_range(0, 1) * 4);
            if ($urandom_range(0, 2) == 0) regs[$urandom_range(0, NW - 1)] = 32'($urandom_range(0, 3));
            step();
        end
        rst = 0;
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
